// File: rtl/buffer_bus_mp_pkg.sv
// Shared constants and entry layout for the multi-port bus receive buffer.
`ifndef BUFFER_BUS_MP_C_LOG_2
`define BUFFER_BUS_MP_C_LOG_2
`define C_LOG_2(x) $clog2(x)
`endif

package buffer_bus_mp_pkg;

  localparam int unsigned DefDataLen    = 16;
  localparam int unsigned DefBusAddrLen = 3;
  localparam int unsigned DefDepth      = 8;
  localparam int unsigned DefNumRd      = 2;
  localparam int unsigned DefFullMargin = 0;

  // Store entry packed as {data, addr, valid}, valid in bit 0.
  localparam int unsigned EntryValidOfs = 0;
  localparam int unsigned EntryAddrOfs  = 1;

  function automatic int unsigned entry_data_ofs(int unsigned addr_len);
    return EntryAddrOfs + addr_len;
  endfunction

  function automatic int unsigned entry_len(int unsigned data_len, int unsigned addr_len);
    return data_len + addr_len + 1;
  endfunction

endpackage

// File: rtl/buffer_bus_rd_port.sv
// One read port: request register, stall handling and retained output data.
module buffer_bus_rd_port
  import buffer_bus_mp_pkg::*;
#(
  parameter int unsigned DATA_LEN     = DefDataLen,
  parameter int unsigned BUS_ADDR_LEN = DefBusAddrLen
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [BUS_ADDR_LEN-1:0] req_addr,
  input  logic                    req,
  input  logic                    hit,
  input  logic [DATA_LEN-1:0]     hit_data,
  output logic                    rq_active,
  output logic [BUS_ADDR_LEN-1:0] rq_addr,
  output logic                    port_valid,
  output logic [DATA_LEN-1:0]     port_data
);

  logic                    rq_q;
  logic [BUS_ADDR_LEN-1:0] addr_q;
  logic                    retain_q;
  logic [DATA_LEN-1:0]     retain_data_q;

  // Load a new request when the consumer is free; otherwise park a hit in the retain slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_q          <= 1'b0;
      addr_q        <= '0;
      retain_q      <= 1'b0;
      retain_data_q <= '0;
    end else if (!stall) begin
      rq_q     <= req;
      addr_q   <= req_addr;
      retain_q <= 1'b0;
    end else if (hit) begin
      rq_q          <= 1'b0;
      retain_q      <= 1'b1;
      retain_data_q <= hit_data;
    end
  end

  // A retained beat blocks further matching until the stall clears.
  always_comb begin
    rq_active  = rq_q & ~retain_q;
    rq_addr    = addr_q;
    port_valid = hit | retain_q;
    port_data  = '0;
    if (retain_q) begin
      port_data = retain_data_q;
    end else if (hit) begin
      port_data = hit_data;
    end
  end

endmodule

// File: rtl/buffer_bus_mp.sv
// Multi-port bus receive buffer: ingress register feeding a compacting associative store.
module buffer_bus_mp
  import buffer_bus_mp_pkg::*;
#(
  parameter int unsigned DATA_LEN     = DefDataLen,
  parameter int unsigned BUS_ADDR_LEN = DefBusAddrLen,
  parameter int unsigned DEPTH        = DefDepth,
  parameter int unsigned NUM_RD       = DefNumRd,
  parameter int unsigned FULL_MARGIN  = DefFullMargin,
  parameter int unsigned CNT_LEN      = `C_LOG_2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_LEN-1:0]            data_from_bus,
  input  logic [BUS_ADDR_LEN-1:0]        addr_from_bus,
  input  logic                           valid_from_bus,
  input  logic [NUM_RD*BUS_ADDR_LEN-1:0] src_addr_in,
  input  logic [NUM_RD-1:0]              src_rq_in,
  input  logic [NUM_RD-1:0]              stall,
  output logic [NUM_RD*DATA_LEN-1:0]     src_data,
  output logic [NUM_RD-1:0]              src_valid,
  output logic [CNT_LEN-1:0]             occupancy,
  output logic                           buffer_full,
  output logic                           overflow
);

  localparam int unsigned DataOfs    = entry_data_ofs(BUS_ADDR_LEN);
  localparam int unsigned EntLen     = entry_len(DATA_LEN, BUS_ADDR_LEN);
  localparam int unsigned FullThresh = DEPTH - FULL_MARGIN;
  localparam int unsigned IdxLen     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EntLen-1:0]       store_q [DEPTH];
  logic [EntLen-1:0]       store_d [DEPTH];
  logic [CNT_LEN-1:0]      cnt_q, cnt_d, surv;
  logic                    in_vld_q, in_vld_d, in_move;
  logic [DATA_LEN-1:0]     in_data_q, in_data_d;
  logic [BUS_ADDR_LEN-1:0] in_addr_q, in_addr_d;
  logic                    ovf_q, ovf_d, full_q, full_d;

  logic [NUM_RD-1:0]       rq_active, hit;
  logic [BUS_ADDR_LEN-1:0] rq_addr  [NUM_RD];
  logic [DATA_LEN-1:0]     hit_data [NUM_RD];
  logic [DEPTH-1:0]        pop;

  // Ports claim matches in index order; a slot taken by a lower port is skipped.
  always_comb begin
    pop = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      hit[p]      = 1'b0;
      hit_data[p] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (rq_active[p] && !hit[p] && !pop[i] && store_q[i][EntryValidOfs] &&
            store_q[i][EntryAddrOfs +: BUS_ADDR_LEN] == rq_addr[p]) begin
          hit[p]      = 1'b1;
          hit_data[p] = store_q[i][DataOfs +: DATA_LEN];
          pop[i]      = 1'b1;
        end
      end
    end
  end

  // Compact survivors toward slot 0 in order, then append the ingress entry if room remains.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      store_d[i] = '0;
    end
    surv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (store_q[i][EntryValidOfs] && !pop[i]) begin
        store_d[surv[IdxLen-1:0]] = store_q[i];
        surv = surv + CNT_LEN'(1);
      end
    end
    in_move = in_vld_q && (surv < CNT_LEN'(DEPTH));
    cnt_d   = surv;
    if (in_move) begin
      store_d[surv[IdxLen-1:0]] = {in_data_q, in_addr_q, 1'b1};
      cnt_d = surv + CNT_LEN'(1);
    end
  end

  // Ingress accepts a beat when it is empty or draining; a blocked beat is lost.
  always_comb begin
    in_vld_d  = in_vld_q;
    in_data_d = in_data_q;
    in_addr_d = in_addr_q;
    ovf_d     = ovf_q;
    if (!in_vld_q || in_move) begin
      in_vld_d  = valid_from_bus;
      in_data_d = data_from_bus;
      in_addr_d = addr_from_bus;
    end else if (valid_from_bus) begin
      ovf_d = 1'b1;
    end
    full_d = ((CNT_LEN+1)'(cnt_d) + (CNT_LEN+1)'(in_vld_d)) >= (CNT_LEN+1)'(FullThresh);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
      cnt_q     <= '0;
      in_vld_q  <= 1'b0;
      in_data_q <= '0;
      in_addr_q <= '0;
      ovf_q     <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= store_d[i];
      end
      cnt_q     <= cnt_d;
      in_vld_q  <= in_vld_d;
      in_data_q <= in_data_d;
      in_addr_q <= in_addr_d;
      ovf_q     <= ovf_d;
      full_q    <= full_d;
    end
  end

  assign occupancy   = cnt_q;
  assign buffer_full = full_q;
  assign overflow    = ovf_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    buffer_bus_rd_port #(
      .DATA_LEN     (DATA_LEN),
      .BUS_ADDR_LEN (BUS_ADDR_LEN)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall[p]),
      .req_addr   (src_addr_in[p*BUS_ADDR_LEN +: BUS_ADDR_LEN]),
      .req        (src_rq_in[p]),
      .hit        (hit[p]),
      .hit_data   (hit_data[p]),
      .rq_active  (rq_active[p]),
      .rq_addr    (rq_addr[p]),
      .port_valid (src_valid[p]),
      .port_data  (src_data[p*DATA_LEN +: DATA_LEN])
    );
  end

endmodule

// File: tb/tb_buffer_bus_mp.sv
// Randomized scoreboard bench for buffer_bus_mp against a queue-level reference model.
module tb_buffer_bus_mp;

  localparam int DL = 16;
  localparam int AL = 3;
  localparam int DP = 8;
  localparam int NR = 2;
  localparam int FM = 2;
  localparam int CL = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [DL-1:0]    data_from_bus;
  logic [AL-1:0]    addr_from_bus;
  logic             valid_from_bus;
  logic [NR*AL-1:0] src_addr_in;
  logic [NR-1:0]    src_rq_in;
  logic [NR-1:0]    stall;
  logic [NR*DL-1:0] src_data;
  logic [NR-1:0]    src_valid;
  logic [CL-1:0]    occupancy;
  logic             buffer_full;
  logic             overflow;

  always #5 clk = ~clk;

  buffer_bus_mp #(
    .DATA_LEN     (DL),
    .BUS_ADDR_LEN (AL),
    .DEPTH        (DP),
    .NUM_RD       (NR),
    .FULL_MARGIN  (FM),
    .CNT_LEN      (CL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_from_bus  (data_from_bus),
    .addr_from_bus  (addr_from_bus),
    .valid_from_bus (valid_from_bus),
    .src_addr_in    (src_addr_in),
    .src_rq_in      (src_rq_in),
    .stall          (stall),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .occupancy      (occupancy),
    .buffer_full    (buffer_full),
    .overflow       (overflow)
  );

  typedef struct packed {
    logic [DL-1:0] d;
    logic [AL-1:0] t;
  } ent_t;

  typedef struct packed {
    logic [CL-1:0] occ;
    logic          full;
    logic          ovf;
  } stat_t;

  // Reference model: store is an arrival-ordered queue.
  ent_t          m_store[$];
  bit            m_in_vld;
  ent_t          m_in;
  bit            m_ovf, m_full;
  bit            m_rq    [NR];
  logic [AL-1:0] m_tag   [NR];
  bit            m_ret   [NR];
  logic [DL-1:0] m_ret_d [NR];
  bit            m_hit   [NR];
  int            m_hit_i [NR];
  logic [DL-1:0] m_hit_d [NR];

  logic [DL-1:0] exp0[$];
  logic [DL-1:0] exp1[$];
  stat_t         exp_stat[$];

  int n_total = 0;
  int n_pass  = 0;
  bit started = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Advance the model across one clock edge using the inputs the DUT just sampled.
  task automatic model_update();
    ent_t ns[$];
    bit   popm[DP];
    bit   move;
    if (rst) begin
      m_store.delete();
      m_in_vld = 0;
      m_ovf    = 0;
      m_full   = 0;
      for (int p = 0; p < NR; p++) begin
        m_rq[p] = 0; m_tag[p] = '0; m_ret[p] = 0; m_ret_d[p] = '0;
      end
      return;
    end
    for (int j = 0; j < DP; j++) popm[j] = 0;
    for (int p = 0; p < NR; p++) if (m_hit[p]) popm[m_hit_i[p]] = 1;
    for (int j = 0; j < m_store.size(); j++) if (!popm[j]) ns.push_back(m_store[j]);
    move = m_in_vld && (ns.size() < DP);
    if (move) ns.push_back(m_in);
    if (m_in_vld && !move) begin
      if (valid_from_bus) m_ovf = 1;
    end else begin
      m_in_vld = valid_from_bus;
      m_in     = '{d: data_from_bus, t: addr_from_bus};
    end
    for (int p = 0; p < NR; p++) begin
      if (!stall[p]) begin
        m_rq[p]  = src_rq_in[p];
        m_tag[p] = src_addr_in[p*AL +: AL];
        m_ret[p] = 0;
      end else if (m_hit[p]) begin
        m_rq[p]    = 0;
        m_ret[p]   = 1;
        m_ret_d[p] = m_hit_d[p];
      end
    end
    m_store = ns;
    m_full  = (m_store.size() + int'(m_in_vld)) >= (DP - FM);
  endtask

  // Work out what each port presents this cycle and queue the expectations.
  task automatic model_eval();
    bit taken[DP];
    for (int j = 0; j < DP; j++) taken[j] = 0;
    for (int p = 0; p < NR; p++) begin
      m_hit[p] = 0;
      if (m_rq[p] && !m_ret[p]) begin
        for (int j = 0; j < m_store.size(); j++) begin
          if (!m_hit[p] && !taken[j] && m_store[j].t == m_tag[p]) begin
            m_hit[p]   = 1;
            m_hit_i[p] = j;
            m_hit_d[p] = m_store[j].d;
            taken[j]   = 1;
          end
        end
      end
      if (m_ret[p] || m_hit[p]) begin
        if (p == 0) exp0.push_back(m_ret[p] ? m_ret_d[p] : m_hit_d[p]);
        else        exp1.push_back(m_ret[p] ? m_ret_d[p] : m_hit_d[p]);
      end
    end
    exp_stat.push_back('{occ: CL'(m_store.size()), full: m_full, ovf: m_ovf});
  endtask

  // Monitor: pops expectations whenever outputs are examined, mid-cycle.
  always @(negedge clk) begin
    stat_t         s;
    logic [DL-1:0] e;
    bit            have;
    if (started) begin
      if (exp_stat.size() > 0) begin
        s = exp_stat.pop_front();
        check("occupancy", 32'(occupancy), 32'(s.occ));
        check("buffer_full", 32'(buffer_full), 32'(s.full));
        check("overflow", 32'(overflow), 32'(s.ovf));
      end
      for (int p = 0; p < NR; p++) begin
        have = (p == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
        if (have) begin
          e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
          check($sformatf("src_valid%0d", p), 32'(src_valid[p]), 32'd1);
          if (src_valid[p]) check($sformatf("src_data%0d", p), 32'(src_data[p*DL +: DL]), 32'(e));
        end else begin
          check($sformatf("src_valid%0d_idle", p), 32'(src_valid[p]), 32'd0);
          check($sformatf("src_data%0d_idle", p), 32'(src_data[p*DL +: DL]), 32'd0);
        end
      end
    end
  end

  // One clock of stimulus: retire the edge in the model, then drive fresh random inputs.
  task automatic cycle(bit r, int pv, int prq, int pst, int tmax);
    @(posedge clk);
    #1;
    model_update();
    model_eval();
    started        = 1'b1;
    rst            = r;
    valid_from_bus = ($urandom_range(99) < pv);
    data_from_bus  = DL'($urandom);
    addr_from_bus  = AL'($urandom_range(tmax));
    for (int p = 0; p < NR; p++) begin
      src_rq_in[p]             = ($urandom_range(99) < prq);
      stall[p]                 = ($urandom_range(99) < pst);
      src_addr_in[p*AL +: AL]  = AL'($urandom_range(tmax));
    end
  endtask

  initial begin
    rst            = 1'b1;
    data_from_bus  = '0;
    addr_from_bus  = '0;
    valid_from_bus = 1'b0;
    src_addr_in    = '0;
    src_rq_in      = '0;
    stall          = '0;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    // Mixed traffic, few tags so requests hit often.
    repeat (300) cycle(0, 50, 50, 25, 3);
    // Build up entries, then reset in the middle of traffic.
    repeat (8) cycle(0, 90, 5, 0, 7);
    cycle(1, 90, 50, 0, 7);
    repeat (3) cycle(0, 0, 0, 0, 7);
    // Fill with no requests: almost-full, full store, dropped beats.
    repeat (14) cycle(0, 100, 0, 0, 7);
    // Pops and appends while full.
    repeat (40) cycle(0, 100, 40, 20, 7);
    // Heavy stalls exercise the retain path.
    repeat (200) cycle(0, 50, 60, 70, 3);
    // Drain.
    repeat (40) cycle(0, 0, 90, 0, 7);
    cycle(1, 0, 0, 0, 0);
    repeat (200) cycle(0, 60, 60, 30, 2);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
